// File: rtl/ffc_pkg.sv
// Shared types and helpers for the flat-field calibration/correction engine.
package ffc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACCUM,
        AVG_PASS,
        FRAME_AVG,
        OFF_PASS
    } t_ffc_state;

    // Unsigned Q0.16 reciprocal of n, rounded to nearest.
    function automatic int unsigned recip_q16(input int unsigned n);
        return (32'd65536 + n / 2) / n;
    endfunction

    // Clamp a signed value to the range of a w-bit signed number (w <= 31).
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/mu_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module mu_ram_1r1w #(
    parameter int unsigned DW    = 18,
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 768
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/ffc_multiframe_engine.sv
// Multi-frame flat-field calibration: averages frames per pixel, stores
// per-pixel offsets against the frame mean, and subtracts them afterwards.
module ffc_multiframe_engine
    import ffc_pkg::*;
#(
    parameter  int unsigned DATAW        = 16,
    parameter  int unsigned NUM_PIXELS   = 768,
    parameter  int unsigned SFRAMES_LOG2 = 2,
    parameter  int unsigned RECIP_Q16    = recip_q16(NUM_PIXELS),
    localparam int unsigned ADDRW        = $clog2(NUM_PIXELS),
    localparam int unsigned SUMW         = DATAW + SFRAMES_LOG2,
    localparam int unsigned FSUMW        = DATAW + ADDRW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pix_valid,
    input  logic [ADDRW-1:0] i_pix_addr,
    input  logic [DATAW-1:0] i_pix_data,
    output logic             o_pix_valid,
    output logic [ADDRW-1:0] o_pix_addr,
    output logic [DATAW-1:0] o_pix_data,
    output logic             o_busy,
    output logic             o_cal_done,
    output logic [DATAW-1:0] o_frame_avg
);

    localparam int unsigned CNTW          = ADDRW + 1;
    localparam int unsigned FCW           = SFRAMES_LOG2 + 1;
    localparam int unsigned SAMPLE_FRAMES = 1 << SFRAMES_LOG2;
    localparam int unsigned RECW          = 18;
    localparam int unsigned PRODW         = FSUMW + RECW;

    t_ffc_state             state, state_nxt;
    logic [FCW-1:0]         frame_cnt;
    logic [CNTW-1:0]        sweep_cnt;
    logic signed [FSUMW-1:0] fsum;

    logic                   p1_valid, p1_acc, p1_first, p1_corr;
    logic [ADDRW-1:0]       p1_addr;
    logic [DATAW-1:0]       p1_data;

    logic [SUMW-1:0]        ram_rdata;
    logic signed [SUMW-1:0] rd_s;
    logic signed [SUMW-1:0] mean_c;
    logic signed [SUMW-1:0] off_c;
    logic signed [SUMW-1:0] acc_sum_c;
    logic signed [PRODW-1:0] prod_c;
    logic [DATAW-1:0]       favg_c;
    logic [DATAW-1:0]       corr_c;

    logic pix_ok_c, last_pix_c, acc_c, sweeping_c, sweep_done_c, sweep_ret_c;
    logic ram_we_c, ram_re_c;
    logic [ADDRW-1:0] ram_waddr_c, ram_raddr_c;
    logic [SUMW-1:0]  ram_wdata_c;

    // Pixel qualification and sweep status.
    assign pix_ok_c     = i_pix_valid && (32'(i_pix_addr) < NUM_PIXELS);
    assign last_pix_c   = pix_ok_c && (32'(i_pix_addr) == NUM_PIXELS - 1);
    assign acc_c        = pix_ok_c && ((state == ACCUM) ||
                                       ((state == WAIT_SOF) && (i_pix_addr == '0)));
    assign sweeping_c   = (state == AVG_PASS) || (state == OFF_PASS);
    assign sweep_done_c = (32'(sweep_cnt) == NUM_PIXELS);
    assign sweep_ret_c  = (sweep_cnt != '0);

    // Datapath arithmetic on the RAM read data.
    assign rd_s      = $signed(ram_rdata);
    assign mean_c    = rd_s >>> SFRAMES_LOG2;
    assign off_c     = mean_c - SUMW'($signed(o_frame_avg));
    assign acc_sum_c = p1_first ? SUMW'($signed(p1_data))
                                : rd_s + SUMW'($signed(p1_data));
    assign prod_c    = PRODW'(fsum) * PRODW'($signed({1'b0, 17'(RECIP_Q16)}));
    assign favg_c    = DATAW'(prod_c >>> 16);
    assign corr_c    = DATAW'(sat_signed(32'($signed(p1_data)) - 32'(rd_s), DATAW));

    // RAM port muxing: sweep owns the read port during the passes.
    assign ram_re_c    = sweeping_c ? !sweep_done_c : pix_ok_c;
    assign ram_raddr_c = sweeping_c ? sweep_cnt[ADDRW-1:0] : i_pix_addr;
    assign ram_we_c    = p1_acc || ((state == OFF_PASS) && sweep_ret_c);
    assign ram_waddr_c = p1_acc ? p1_addr : ADDRW'(sweep_cnt - CNTW'(1));
    assign ram_wdata_c = p1_acc ? acc_sum_c : off_c;

    mu_ram_1r1w #(
        .DW    (SUMW),
        .AW    (ADDRW),
        .DEPTH (NUM_PIXELS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we_c),
        .i_waddr (ram_waddr_c),
        .i_wdata (ram_wdata_c),
        .i_re    (ram_re_c),
        .i_raddr (ram_raddr_c),
        .o_rdata (ram_rdata)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_start) state_nxt = WAIT_SOF;
            WAIT_SOF,
            ACCUM: begin
                if (acc_c && last_pix_c)
                    state_nxt = (frame_cnt == FCW'(SAMPLE_FRAMES - 1)) ? AVG_PASS : WAIT_SOF;
                else if (acc_c)
                    state_nxt = ACCUM;
            end
            AVG_PASS:  if (sweep_done_c) state_nxt = FRAME_AVG;
            FRAME_AVG: state_nxt = OFF_PASS;
            OFF_PASS:  if (sweep_done_c) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register plus calibration bookkeeping and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            fsum        <= '0;
            o_busy      <= 1'b0;
            o_cal_done  <= 1'b0;
            o_frame_avg <= '0;
        end else begin
            state  <= state_nxt;
            o_busy <= (state_nxt != IDLE);
            case (state)
                IDLE: if (i_start) begin
                    frame_cnt  <= '0;
                    fsum       <= '0;
                    o_cal_done <= 1'b0;
                end
                WAIT_SOF,
                ACCUM:     if (acc_c && last_pix_c) frame_cnt <= frame_cnt + 1'b1;
                AVG_PASS:  if (sweep_ret_c) fsum <= fsum + FSUMW'(mean_c);
                FRAME_AVG: o_frame_avg <= favg_c;
                OFF_PASS:  if (sweep_done_c) o_cal_done <= 1'b1;
                default: ;
            endcase
        end
    end

    // Sweep address counter for the averaging and offset passes.
    always_ff @(posedge i_clk) begin
        if (i_rst)                            sweep_cnt <= '0;
        else if (sweeping_c && !sweep_done_c) sweep_cnt <= sweep_cnt + 1'b1;
        else                                  sweep_cnt <= '0;
    end

    // Two-stage pixel pipeline: RAM lookup, then correction or pass-through.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_valid    <= 1'b0;
            p1_acc      <= 1'b0;
            p1_first    <= 1'b0;
            p1_corr     <= 1'b0;
            p1_addr     <= '0;
            p1_data     <= '0;
            o_pix_valid <= 1'b0;
            o_pix_addr  <= '0;
            o_pix_data  <= '0;
        end else begin
            p1_valid    <= pix_ok_c;
            p1_acc      <= acc_c;
            p1_first    <= (frame_cnt == '0);
            p1_corr     <= (state == IDLE) && o_cal_done;
            p1_addr     <= i_pix_addr;
            p1_data     <= i_pix_data;
            o_pix_valid <= p1_valid;
            o_pix_addr  <= p1_addr;
            o_pix_data  <= p1_corr ? corr_c : p1_data;
        end
    end

endmodule

// File: doc/ffc_multiframe_engine.md
# ffc_multiframe_engine

Multi-frame flat-field calibration and correction engine for the thermal sensor pixel stream. On request it averages SAMPLE_FRAMES raw frames per pixel, computes the frame-wide mean, and stores a signed per-pixel offset (pixel mean minus frame mean). Outside calibration it subtracts the stored offset from every incoming pixel. It sits between the sensor frame reader and the normalisation/colour-map stage.

## Interface
- DATAW, 16: raw and corrected pixel width, signed two's complement
- NUM_PIXELS, 768: pixels per frame; addresses 0..NUM_PIXELS-1
- SFRAMES_LOG2, 2: log2 of frames averaged per calibration; SAMPLE_FRAMES = 2**SFRAMES_LOG2, range 0..4
- RECIP_Q16, 85: round(65536/NUM_PIXELS), unsigned Q0.16 reciprocal used for the frame mean
- Derived: ADDRW = $clog2(NUM_PIXELS); SUMW = DATAW+SFRAMES_LOG2; FSUMW = DATAW+ADDRW+1
- i_clk  in  1  clock
- i_rst  in  1  reset: i_rst, synchronous, active-high; clock i_clk
- i_start  in  1  single-cycle calibration request
- i_pix_valid  in  1  input pixel strobe
- i_pix_addr  in  ADDRW  input pixel address
- i_pix_data  in  DATAW  signed raw pixel
- o_pix_valid  out  1  output pixel strobe
- o_pix_addr  out  ADDRW  output pixel address
- o_pix_data  out  DATAW  signed corrected (or raw) pixel
- o_busy  out  1  calibration in progress
- o_cal_done  out  1  a valid offset table is stored
- o_frame_avg  out  DATAW  signed frame mean from the last calibration

## Operation
- States: IDLE, WAIT_SOF, ACCUM, AVG_PASS, FRAME_AVG, OFF_PASS.
- IDLE: i_start -> WAIT_SOF, frame_cnt=0, o_cal_done=0. i_start in any other state is ignored.
- WAIT_SOF: i_pix_valid with i_pix_addr==0 -> ACCUM; that pixel is processed.
- ACCUM: each valid pixel does read-modify-write on the sum RAM at its address. For frame_cnt==0 write sign-extended raw (no RAM clear needed); otherwise write sum+raw. On pixel NUM_PIXELS-1: frame_cnt++. If frame_cnt reaches SAMPLE_FRAMES -> AVG_PASS, otherwise -> WAIT_SOF.
- AVG_PASS: sweep addr 0..NUM_PIXELS-1 at one read per cycle. fsum += sum>>>SFRAMES_LOG2 (arithmetic shift). After the last read returns -> FRAME_AVG.
- FRAME_AVG: one cycle. frame_avg = (fsum*RECIP_Q16)>>>16, signed, truncated to DATAW. Then -> OFF_PASS.
- OFF_PASS: sweep 0..NUM_PIXELS-1. Write offset = (sum>>>SFRAMES_LOG2) - frame_avg in place, SUMW-wide signed. After the last write: o_cal_done=1 -> IDLE.
- Correction is active in IDLE with o_cal_done=1: o_pix_data = sat_DATAW(i_pix_data - offset[addr]), saturating to signed min/max.
- Pass-through: raw data is forwarded unchanged while o_cal_done=0, including throughout calibration. The output stream is never stalled.
- Gaps in i_pix_valid are allowed in every state. Addresses outside 0..NUM_PIXELS-1 are dropped: no RAM write, no output.
- Reset: state IDLE. o_busy=0, o_cal_done=0, o_frame_avg=0, o_pix_valid=0, fsum=0, frame_cnt=0. RAM contents are not reset. Reset mid-calibration discards everything; o_cal_done stays 0 until a full recalibration completes.

## Timing
- RAM is 1R1W with registered read, 1-cycle latency.
- Pixel path: input at cycle t -> o_pix_* at t+2, in every state.
- ACCUM read-modify-write: read at t, write at t+1. Back-to-back pixels use distinct addresses, so there is no hazard. An address repeated on consecutive cycles is not supported.
- AVG_PASS takes NUM_PIXELS+1 cycles; OFF_PASS takes NUM_PIXELS+1 cycles; FRAME_AVG takes 1 cycle.
- o_busy is high from the cycle after i_start through the last OFF_PASS write. o_cal_done rises one cycle later, together with the IDLE entry.
- Input pixels arriving during AVG_PASS, FRAME_AVG or OFF_PASS are passed through raw and are never accumulated.
- Calibration time is SAMPLE_FRAMES frames plus 2*NUM_PIXELS+3 cycles, plus the wait for SOF.

## Structure
- Package ffc_pkg holds:
  - the t_ffc_state enum
  - the sat_signed function
  - a recip_q16(n) constant function, so RECIP_Q16 can default from NUM_PIXELS
- Sub-module: the existing mu_ram_1r1w, DW=SUMW, AW=ADDRW, depth NUM_PIXELS. It stores sums in ACCUM and offsets from OFF_PASS onward.
- Control is a state register plus a next-state always_comb. The 2-stage pixel pipeline is kept separate from the sweep address counter.

## Test plan
- Reset then stream a frame with pixel=addr: output equals input, 2-cycle latency, o_cal_done=0.
- SFRAMES_LOG2=2, four frames all pixels 1000 -> o_frame_avg=1000 (within ±1 due to RECIP_Q16). The next frame of 1000s outputs 1000±1.
- One frame pixel[5]=1300, others 1000 -> offset[5]≈+300. Next frame of 1000s gives out[5]≈700, others ≈1000.
- Negative data (all pixels -200, pixel[0]=-32768) -> arithmetic shifts correct, frame_avg ≈ -242. Correction of pixel 0 with input 32767 and offset negative saturates to 32767.
- Gaps in valid, plus an i_start issued mid-ACCUM (ignored), plus a stray address 800 (dropped) -> calibration result identical to the gap-free run.
- Assert i_rst during OFF_PASS -> o_busy=0, o_cal_done=0, output reverts to raw pass-through.
